score_tracker: RTL and testbench
================================

// Module: score_tracker
// PURPOSE
//  Multi-lane successor to the single-lane scorer for the rhythm game: takes per-lane
//  correct/incorrect hit levels from the note judge, synchronises and edge-detects them,
//  and keeps score, combo, tiered multiplier, best combo and miss count under the
//  2-bit game state from the top-level FSM. Feeds the seven-segment/VGA display path.
// PARAMETERS
//  NUM_LANES  4   number of input lanes (1..8)
//  SCORE_W    14  score width; saturates at 2^SCORE_W-1
//  COMBO_W    14  combo / max_combo width; saturate at all-ones
//  MISS_W     10  miss counter width; saturates
//  T1,T2,T3   3,6,10   combo thresholds for tiers 1..3 (T1<T2<T3 required)
//  M1,M2,M3   2,4,8    multipliers for tiers 1..3 (tier 0 = x1; M3<=15)
// PORTS
//  clk            in   1          system clock
//  rst_n          in   1          asynchronous active-low reset
//  state          in   2          0=PLAY, 1=PAUSE, 2=RESET, 3=OVER
//  correct_hit    in   NUM_LANES  per-lane level, rising edge = one hit
//  incorrect_hit  in   NUM_LANES  per-lane level, rising edge = one miss
//  score          out  SCORE_W    running score
//  combo_count    out  COMBO_W    current consecutive-hit count
//  max_combo      out  COMBO_W    best combo since last RESET
//  multiplier     out  4          tier multiplier for current combo (1,M1,M2,M3)
//  miss_count     out  MISS_W     misses since last RESET
//  high_score     out  SCORE_W    only with SCORE_HISCORE_EN; else tied 0
// BEHAVIOUR
//  - rst_n low: all registers incl. sync/edge flops clear; multiplier=1, others 0. Async assert, sync release.
//  - Input path per lane: 2-flop synchroniser -> edge flop; pulse = sync2 & ~edge, registered.
//    Level rising before edge k -> pulse valid after k+2 -> outputs update at edge k+3.
//  - Per cycle: h = popcount(hit pulses), m = popcount(miss pulses), 0..NUM_LANES each.
//  - PLAY, m>0: combo<=0, multiplier<=1, miss_count<=sat(miss_count+m); same-cycle hits discarded.
//  - PLAY, m==0, h>0: score<=sat(score + h*multiplier) using multiplier BEFORE update;
//    combo<=sat(combo+h); multiplier<=tier(new combo); max_combo<=max(max_combo,new combo).
//  - tier(c): c>=T3 -> M3; c>=T2 -> M2; c>=T1 -> M1; else 1.
//  - Arithmetic: full-width intermediates (SCORE_W+4 bits); clamp, never wrap.
//  - PAUSE: all scoring regs hold; pulses arriving while paused are dropped (not queued);
//    sync/edge flops keep running so a level held across un-pause does not re-trigger.
//  - RESET: score, combo, max_combo, miss_count <=0, multiplier<=1 each cycle state==2; pulses dropped.
//  - OVER: all outputs frozen; pulses dropped.
//  - state sampled directly at clk (already synchronous to clk); a change takes effect that edge.
//  - Saturated combo keeps multiplier M3 and stops incrementing; miss still clears it.
// CONFIGURATION
//  SCORE_HISCORE_EN defined: high_score register, cleared only by rst_n (survives RESET);
//    on every clock where state==3 and score>high_score, high_score<=score.
//  Not defined: no register; high_score driven constant 0.
// TESTING
//  1 rst_n low mid-game (score=57) -> all outputs 0, multiplier=1 immediately, before clk.
//  2 PLAY, 7 single-lane hits spaced 4 clk -> score 1+1+1+2+2+2+4=13, combo 7,
//    multiplier 4, each update exactly 3 clk after input rise.
//  3 PLAY, combo=5 (mult 2), lanes 0,1,2 rise same cycle -> score +6, combo 8, mult 4;
//    then lane 1 hit + lane 3 miss same cycle -> score unchanged, combo 0, mult 1, miss +1, max_combo 8.
//  4 score=16380 (SCORE_W 14), mult 4, one hit -> score 16383, holds there on further hits.
//  5 PAUSE, hit pulse, then PLAY with lane still high -> no change; RESET -> all cleared,
//    max_combo 0, miss_count 0.
//  6 SCORE_HISCORE_EN: finish at 120, OVER -> high_score 120; RESET, finish at 90, OVER -> stays 120.

Source files
------------

// File: rtl/score_tracker_if.sv
// Bundle between the game controller / note judge (master) and score_tracker (slave).
interface score_tracker_if #(
    parameter int NUM_LANES = 4,
    parameter int SCORE_W   = 14,
    parameter int COMBO_W   = 14,
    parameter int MISS_W    = 10
);
    logic [1:0]           state;
    logic [NUM_LANES-1:0] correct_hit;
    logic [NUM_LANES-1:0] incorrect_hit;
    logic [SCORE_W-1:0]   score;
    logic [COMBO_W-1:0]   combo_count;
    logic [COMBO_W-1:0]   max_combo;
    logic [3:0]           multiplier;
    logic [MISS_W-1:0]    miss_count;
    logic [SCORE_W-1:0]   high_score;

    modport master (
        output state, correct_hit, incorrect_hit,
        input  score, combo_count, max_combo, multiplier, miss_count, high_score
    );

    modport slave (
        input  state, correct_hit, incorrect_hit,
        output score, combo_count, max_combo, multiplier, miss_count, high_score
    );
endinterface

// File: rtl/score_tracker.sv
// Multi-lane rhythm-game scorer: synchronised hit/miss edges drive saturating score, combo,
// tiered multiplier, best combo and miss count. Optional high score under SCORE_HISCORE_EN.
module score_tracker #(
    parameter int NUM_LANES = 4,
    parameter int SCORE_W   = 14,
    parameter int COMBO_W   = 14,
    parameter int MISS_W    = 10,
    parameter int T1        = 3,
    parameter int T2        = 6,
    parameter int T3        = 10,
    parameter int M1        = 2,
    parameter int M2        = 4,
    parameter int M3        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    score_tracker_if.slave   bus
);
    localparam int WIDE_W  = SCORE_W + 4;
    localparam int CWIDE_W = COMBO_W + 4;
    localparam int MWIDE_W = MISS_W + 4;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_PAUSE = 2'd1,
        ST_RESET = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    function automatic logic [3:0] popcount(input logic [NUM_LANES-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [3:0] tier(input logic [COMBO_W-1:0] c);
        logic [3:0] t;
        if (c >= COMBO_W'(T3)) begin
            t = 4'(M3);
        end else if (c >= COMBO_W'(T2)) begin
            t = 4'(M2);
        end else if (c >= COMBO_W'(T1)) begin
            t = 4'(M1);
        end else begin
            t = 4'd1;
        end
        return t;
    endfunction

    game_state_e          state_s;
    logic [NUM_LANES-1:0] hit_s1_q, hit_s2_q, hit_edge_q, hit_pulse_q;
    logic [NUM_LANES-1:0] miss_s1_q, miss_s2_q, miss_edge_q, miss_pulse_q;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [COMBO_W-1:0]   combo_q, combo_d;
    logic [COMBO_W-1:0]   max_q, max_d;
    logic [3:0]           mult_q, mult_d;
    logic [MISS_W-1:0]    miss_q, miss_d;
    logic [3:0]           h_s, m_s;
    logic [WIDE_W-1:0]    score_sum_s;
    logic [CWIDE_W-1:0]   combo_sum_s;
    logic [MWIDE_W-1:0]   miss_sum_s;
    logic [SCORE_W-1:0]   score_sat_s;
    logic [COMBO_W-1:0]   combo_sat_s;
    logic [MISS_W-1:0]    miss_sat_s;

    assign state_s = game_state_e'(bus.state);

    // Two-flop synchroniser, edge flop and registered rising-edge pulse per lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_s1_q     <= {NUM_LANES{1'b0}};
            hit_s2_q     <= {NUM_LANES{1'b0}};
            hit_edge_q   <= {NUM_LANES{1'b0}};
            hit_pulse_q  <= {NUM_LANES{1'b0}};
            miss_s1_q    <= {NUM_LANES{1'b0}};
            miss_s2_q    <= {NUM_LANES{1'b0}};
            miss_edge_q  <= {NUM_LANES{1'b0}};
            miss_pulse_q <= {NUM_LANES{1'b0}};
        end else begin
            hit_s1_q     <= bus.correct_hit;
            hit_s2_q     <= hit_s1_q;
            hit_edge_q   <= hit_s2_q;
            hit_pulse_q  <= hit_s2_q & ~hit_edge_q;
            miss_s1_q    <= bus.incorrect_hit;
            miss_s2_q    <= miss_s1_q;
            miss_edge_q  <= miss_s2_q;
            miss_pulse_q <= miss_s2_q & ~miss_edge_q;
        end
    end

    // Wide sums so that every counter clamps at all-ones instead of wrapping.
    always_comb begin
        h_s         = popcount(hit_pulse_q);
        m_s         = popcount(miss_pulse_q);
        score_sum_s = WIDE_W'(score_q) + (WIDE_W'(h_s) * WIDE_W'(mult_q));
        combo_sum_s = CWIDE_W'(combo_q) + CWIDE_W'(h_s);
        miss_sum_s  = MWIDE_W'(miss_q) + MWIDE_W'(m_s);
        score_sat_s = (|score_sum_s[WIDE_W-1:SCORE_W]) ? {SCORE_W{1'b1}} : score_sum_s[SCORE_W-1:0];
        combo_sat_s = (|combo_sum_s[CWIDE_W-1:COMBO_W]) ? {COMBO_W{1'b1}} : combo_sum_s[COMBO_W-1:0];
        miss_sat_s  = (|miss_sum_s[MWIDE_W-1:MISS_W]) ? {MISS_W{1'b1}} : miss_sum_s[MISS_W-1:0];
    end

    // Next-state scoring; a miss in a cycle overrides any hits in that same cycle.
    always_comb begin
        score_d = score_q;
        combo_d = combo_q;
        max_d   = max_q;
        mult_d  = mult_q;
        miss_d  = miss_q;
        case (state_s)
            ST_PLAY: begin
                if (m_s != 4'd0) begin
                    combo_d = {COMBO_W{1'b0}};
                    mult_d  = 4'd1;
                    miss_d  = miss_sat_s;
                end else if (h_s != 4'd0) begin
                    score_d = score_sat_s;
                    combo_d = combo_sat_s;
                    mult_d  = tier(combo_sat_s);
                    max_d   = (combo_sat_s > max_q) ? combo_sat_s : max_q;
                end else begin
                    score_d = score_q;
                end
            end
            ST_RESET: begin
                score_d = {SCORE_W{1'b0}};
                combo_d = {COMBO_W{1'b0}};
                max_d   = {COMBO_W{1'b0}};
                mult_d  = 4'd1;
                miss_d  = {MISS_W{1'b0}};
            end
            ST_PAUSE: score_d = score_q;
            ST_OVER:  score_d = score_q;
            default:  score_d = score_q;
        endcase
    end

    // Scoring registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= {SCORE_W{1'b0}};
            combo_q <= {COMBO_W{1'b0}};
            max_q   <= {COMBO_W{1'b0}};
            mult_q  <= 4'd1;
            miss_q  <= {MISS_W{1'b0}};
        end else begin
            score_q <= score_d;
            combo_q <= combo_d;
            max_q   <= max_d;
            mult_q  <= mult_d;
            miss_q  <= miss_d;
        end
    end

    assign bus.score       = score_q;
    assign bus.combo_count = combo_q;
    assign bus.max_combo   = max_q;
    assign bus.multiplier  = mult_q;
    assign bus.miss_count  = miss_q;

`ifdef SCORE_HISCORE_EN
    logic [SCORE_W-1:0] high_q, high_d;

    // High score only advances while the game is over; RESET state leaves it alone.
    always_comb begin
        if ((state_s == ST_OVER) && (score_q > high_q)) begin
            high_d = score_q;
        end else begin
            high_d = high_q;
        end
    end

    // High score register, cleared only by power-on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_q <= {SCORE_W{1'b0}};
        end else begin
            high_q <= high_d;
        end
    end

    assign bus.high_score = high_q;
`else
    assign bus.high_score = {SCORE_W{1'b0}};
`endif
endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker: directed vector table plus hand-written latency,
// pause/reset, saturation, asynchronous reset and high-score sequences.
module tb_score_tracker;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    score_tracker_if #(.NUM_LANES(4), .SCORE_W(14), .COMBO_W(14), .MISS_W(10)) bus ();

    score_tracker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic [3:0] hit;
        logic [3:0] miss;
        int         score;
        int         combo;
        int         maxc;
        int         mult;
        int         missn;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int s, input int c, input int mx,
                             input int mu, input int ms);
        check({name, ".score"},  int'(bus.score), s);
        check({name, ".combo"},  int'(bus.combo_count), c);
        check({name, ".max"},    int'(bus.max_combo), mx);
        check({name, ".mult"},   int'(bus.multiplier), mu);
        check({name, ".miss"},   int'(bus.miss_count), ms);
    endtask

    // One-cycle level pulse on the chosen lanes; returns sampled after the update edge.
    task automatic fire(input logic [3:0] h, input logic [3:0] m);
        @(negedge clk);
        bus.correct_hit   = h;
        bus.incorrect_hit = m;
        @(negedge clk);
        bus.correct_hit   = 4'b0000;
        bus.incorrect_hit = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int hi_exp;
`ifdef SCORE_HISCORE_EN
        hi_exp = 120;
`else
        hi_exp = 0;
`endif
        n_pass  = 0;
        n_total = 0;
        vecs[0]  = '{2'd0, 4'b0001, 4'b0000,  1,  1,  1, 1, 0};
        vecs[1]  = '{2'd0, 4'b0010, 4'b0000,  2,  2,  2, 1, 0};
        vecs[2]  = '{2'd0, 4'b0100, 4'b0000,  3,  3,  3, 2, 0};
        vecs[3]  = '{2'd0, 4'b1000, 4'b0000,  5,  4,  4, 2, 0};
        vecs[4]  = '{2'd0, 4'b0001, 4'b0000,  7,  5,  5, 2, 0};
        vecs[5]  = '{2'd0, 4'b0010, 4'b0000,  9,  6,  6, 4, 0};
        vecs[6]  = '{2'd0, 4'b0100, 4'b0000, 13,  7,  7, 4, 0};
        vecs[7]  = '{2'd0, 4'b0000, 4'b0100, 13,  0,  7, 1, 1};
        vecs[8]  = '{2'd0, 4'b0011, 4'b0000, 15,  2,  7, 1, 1};
        vecs[9]  = '{2'd0, 4'b0111, 4'b0000, 18,  5,  7, 2, 1};
        vecs[10] = '{2'd0, 4'b0111, 4'b0000, 24,  8,  8, 4, 1};
        vecs[11] = '{2'd0, 4'b0010, 4'b1000, 24,  0,  8, 1, 2};
        vecs[12] = '{2'd0, 4'b1111, 4'b0000, 28,  4,  8, 2, 2};
        vecs[13] = '{2'd0, 4'b1111, 4'b0000, 36,  8,  8, 4, 2};
        vecs[14] = '{2'd0, 4'b1111, 4'b0000, 52, 12, 12, 8, 2};
        vecs[15] = '{2'd0, 4'b0000, 4'b1111, 52,  0, 12, 1, 6};
        vecs[16] = '{2'd1, 4'b0001, 4'b0000, 52,  0, 12, 1, 6};
        vecs[17] = '{2'd3, 4'b0001, 4'b0000, 52,  0, 12, 1, 6};
        vecs[18] = '{2'd2, 4'b0000, 4'b0000,  0,  0,  0, 1, 0};
        vecs[19] = '{2'd0, 4'b0001, 4'b0000,  1,  1,  1, 1, 0};

        rst_n             = 1'b0;
        bus.state         = 2'd0;
        bus.correct_hit   = 4'b0000;
        bus.incorrect_hit = 4'b0000;
        repeat (2) @(negedge clk);
        check_all("reset", 0, 0, 0, 1, 0);
        check("reset.high", int'(bus.high_score), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            bus.state = vecs[i].st;
            fire(vecs[i].hit, vecs[i].miss);
            check_all($sformatf("v%0d", i), vecs[i].score, vecs[i].combo, vecs[i].maxc,
                      vecs[i].mult, vecs[i].missn);
        end

        // Latency: rise before edge k, update visible only after edge k+3.
        @(negedge clk);
        bus.correct_hit = 4'b0100;
        @(negedge clk);
        check("lat_k0", int'(bus.score), 1);
        bus.correct_hit = 4'b0000;
        @(negedge clk);
        check("lat_k1", int'(bus.score), 1);
        @(negedge clk);
        check("lat_k2", int'(bus.score), 1);
        @(negedge clk);
        check("lat_k3.score", int'(bus.score), 2);
        check("lat_k3.combo", int'(bus.combo_count), 2);

        // Pause drops the pulse; a level held across un-pause must not re-trigger.
        fire(4'b0000, 4'b0001);
        check_all("premiss", 2, 0, 2, 1, 1);
        bus.state = 2'd1;
        bus.correct_hit = 4'b0001;
        repeat (5) @(negedge clk);
        bus.state = 2'd0;
        repeat (5) @(negedge clk);
        check_all("unpause", 2, 0, 2, 1, 1);
        bus.correct_hit = 4'b0000;
        repeat (3) @(negedge clk);
        bus.state = 2'd2;
        @(negedge clk);
        check_all("rst_state", 0, 0, 0, 1, 0);
        bus.state = 2'd0;

        // Saturation: climb to 16372, miss, rebuild to 16380 at x4, then clamp at 16383.
        repeat (3) fire(4'b1111, 4'b0000);
        check("sat_ramp", int'(bus.score), 28);
        repeat (510) fire(4'b1111, 4'b0000);
        repeat (3) fire(4'b0001, 4'b0000);
        check("sat_pre", int'(bus.score), 16372);
        fire(4'b0000, 4'b0001);
        fire(4'b1111, 4'b0000);
        fire(4'b0011, 4'b0000);
        check("sat_16380", int'(bus.score), 16380);
        check("sat_mult4", int'(bus.multiplier), 4);
        fire(4'b0001, 4'b0000);
        check("sat_clamp", int'(bus.score), 16383);
        check("sat_combo7", int'(bus.combo_count), 7);
        fire(4'b0001, 4'b0000);
        check("sat_hold", int'(bus.score), 16383);
        check("sat_combo8", int'(bus.combo_count), 8);

        // Asynchronous reset clears outputs between clock edges.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // High score: latched in OVER, survives the RESET game state.
        bus.state = 2'd0;
        fire(4'b1111, 4'b0000);
        repeat (2) fire(4'b0001, 4'b0000);
        repeat (4) fire(4'b1111, 4'b0000);
        check("hs_score120", int'(bus.score), 120);
        check("hs_play", int'(bus.high_score), 0);
        bus.state = 2'd3;
        @(negedge clk);
        check("hs_over1", int'(bus.high_score), hi_exp);
        fire(4'b1111, 4'b0000);
        check("hs_frozen", int'(bus.score), 120);
        bus.state = 2'd2;
        @(negedge clk);
        bus.state = 2'd0;
        check("hs_after_rst", int'(bus.high_score), hi_exp);
        fire(4'b1111, 4'b0000);
        repeat (2) fire(4'b0001, 4'b0000);
        repeat (3) fire(4'b1111, 4'b0000);
        check("hs_score88", int'(bus.score), 88);
        bus.state = 2'd3;
        repeat (2) @(negedge clk);
        check("hs_over2", int'(bus.high_score), hi_exp);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
